// File: rtl/div_unit.sv
// div_unit -- multi-cycle radix-2 restoring divider (DIV / DIVU).
//
// The execute stage raises start with the operands. The unit divides the
// operand magnitudes over WIDTH iterations, applies the sign fixup on one
// extra edge, and then presents quotient (to LO) and remainder (to HI) with
// result_valid.
//
// Handshake: result_valid stays high, with quotient/remainder stable, until
// an edge where result_ready is also high; that edge is the transfer. A new
// start is taken only in IDLE, or in DONE on the same edge as the transfer
// (back-to-back). cancel overrides everything and returns the unit to IDLE.
//
// Ports:
//   clk           rising-edge clock
//   resetn        asynchronous, active-low reset
//   start         request (see above for when it is sampled)
//   is_signed     1 = two's-complement DIV, 0 = DIVU; sampled with start
//   dividend      numerator; sampled with start
//   divisor       denominator; sampled with start
//   cancel        pipeline flush; aborts any operation
//   busy          high while iterating
//   result_valid  result available, held until accepted
//   result_ready  consumer accepts the result
//   quotient      quotient (LO)
//   remainder     remainder (HI)
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             cancel,
    output logic             busy,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] div_r;
    logic [WIDTH-1:0] dividend_raw;
    logic             sign_q;
    logic             sign_r;
    logic             div0;
    logic [CW-1:0]    counter;

    logic             load;
    logic             iter_done;
    logic [WIDTH-1:0] dividend_abs;
    logic [WIDTH-1:0] divisor_abs;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   diff;
    logic             take;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] quo_nxt;

    // A request is accepted only when the unit is free or is handing off
    // its result on this very edge; cancel wins over start.
    assign load = !cancel && start &&
                  ((state == IDLE) || ((state == DONE) && result_ready));

    assign iter_done = (counter == CW'(WIDTH));

    assign dividend_abs = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
    assign divisor_abs  = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;

    // One restoring step. The shifted partial remainder needs one extra bit
    // because an unsigned divisor can use the full WIDTH; the top bit of the
    // trial subtraction is the borrow (set when rem_sh < divisor).
    assign rem_sh  = {rem_r, quo_r[WIDTH-1]};
    assign diff    = rem_sh - {1'b0, div_r};
    assign take    = !diff[WIDTH];
    assign rem_nxt = take ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    assign quo_nxt = {quo_r[WIDTH-2:0], take};

    assign busy         = (state == BUSY);
    assign result_valid = (state == DONE);

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (load) state_next = BUSY;
            BUSY: if (iter_done) state_next = DONE;
            DONE: if (result_ready) state_next = load ? BUSY : IDLE;
            default: state_next = IDLE;
        endcase
        if (cancel) state_next = IDLE;
    end

    // Datapath
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rem_r        <= '0;
            quo_r        <= '0;
            div_r        <= '0;
            dividend_raw <= '0;
            sign_q       <= 1'b0;
            sign_r       <= 1'b0;
            div0         <= 1'b0;
            counter      <= '0;
            quotient     <= '0;
            remainder    <= '0;
        end else if (!cancel) begin
            if (load) begin
                // Dividend magnitude starts in the quotient register and is
                // shifted into the partial remainder one bit per iteration.
                rem_r        <= '0;
                quo_r        <= dividend_abs;
                div_r        <= divisor_abs;
                dividend_raw <= dividend;
                sign_q       <= is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                sign_r       <= is_signed && dividend[WIDTH-1];
                div0         <= (divisor == '0);
                counter      <= '0;
            end else if (state == BUSY) begin
                if (!iter_done) begin
                    rem_r   <= rem_nxt;
                    quo_r   <= quo_nxt;
                    counter <= counter + CW'(1);
                end else if (div0) begin
                    // Divide by zero: the iterations naturally yield all-ones;
                    // the remainder is the operand exactly as it was given.
                    quotient  <= quo_r;
                    remainder <= dividend_raw;
                end else begin
                    // MIN_INT / -1 falls out of this: magnitude 2^(WIDTH-1)
                    // negates to itself.
                    quotient  <= sign_q ? -quo_r : quo_r;
                    remainder <= sign_r ? -rem_r : rem_r;
                end
            end
        end
    end

endmodule
